// File: rtl/gpu_fifo_pkg.sv
// Shared types and helpers for the GPU pipeline FIFOs.
// Provides the read-mode constants, level width helper and flag bundle.
package gpu_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{
    full:      1'b0,
    empty:     1'b1,
    afull:     1'b0,
    aempty:    1'b1,
    overflow:  1'b0,
    underflow: 1'b0
  };

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_fwft_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) ();
  import gpu_fifo_pkg::*;

  localparam int LW = level_width(ADDR_WIDTH);

  logic                  flush_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [LW-1:0]         level_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i,
    output wr_en_i,
    output wr_data_i,
    output rd_en_i,
    input  rd_data_o,
    input  full_o,
    input  empty_o,
    input  almost_full_o,
    input  almost_empty_o,
    input  level_o,
    input  overflow_o,
    input  underflow_o
  );

  modport slave (
    input  flush_i,
    input  wr_en_i,
    input  wr_data_i,
    input  rd_en_i,
    output rd_data_o,
    output full_o,
    output empty_o,
    output almost_full_o,
    output almost_empty_o,
    output level_o,
    output overflow_o,
    output underflow_o
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one clock, registered read port.
// Ports: we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o data.
module sync_fifo_ram #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is cleared; it holds when re_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read.
// Ports: clk_i, rst_i (async high), bus (slave modport of the FIFO bundle).
module sync_fifo_fwft
  import gpu_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sync_fifo_fwft_if.slave bus
);

  localparam int LW    = level_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  fifo_flags_t           flags_q;
  fifo_flags_t           flags_d;
  logic                  push;
  logic                  pop;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    push    = bus.wr_en_i & ~flags_q.full & ~bus.flush_i;
    pop     = bus.rd_en_i & ~flags_q.empty & ~bus.flush_i;
    ram_cnt = wr_ptr_q - rd_ptr_q;

    // In FWFT mode the RAM read register is the presented word.
    // Refill it whenever it is empty or being consumed.
    if (FWFT == FIFO_MODE_FWFT) begin
      ram_re = (ram_cnt != '0)
             & (~out_valid_q | pop)
             & ~bus.flush_i;
      out_valid_d = ram_re | (out_valid_q & ~pop);
    end else begin
      ram_re      = pop;
      out_valid_d = 1'b0;
    end

    level_d = level_q + LW'(push) - LW'(pop);

    flags_d        = flags_q;
    flags_d.full   = (level_d == DEPTH_L);
    flags_d.afull  = (level_d >= AF_L);
    flags_d.aempty = (level_d <= AE_L);
    if (FWFT == FIFO_MODE_FWFT) begin
      flags_d.empty = ~out_valid_d;
    end else begin
      flags_d.empty = (level_d == '0);
    end
    flags_d.overflow  = flags_q.overflow
                      | (bus.wr_en_i & flags_q.full);
    flags_d.underflow = flags_q.underflow
                      | (bus.rd_en_i & flags_q.empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= FLAGS_RST;
    end else if (bus.flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= FLAGS_RST;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (ram_re) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  sync_fifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.wr_data_i),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign bus.rd_data_o      = ram_rdata;
  assign bus.full_o         = flags_q.full;
  assign bus.empty_o        = flags_q.empty;
  assign bus.almost_full_o  = flags_q.afull;
  assign bus.almost_empty_o = flags_q.aempty;
  assign bus.level_o        = level_q;
  assign bus.overflow_o     = flags_q.overflow;
  assign bus.underflow_o    = flags_q.underflow;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft in standard and FWFT modes.
// One instance per read mode, shared clock and reset.
module tb_sync_fifo_fwft;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sync_fifo_fwft_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus0 ();
  sync_fifo_fwft_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus1 ();

  sync_fifo_fwft #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (32),
    .FWFT       (0)
  ) u_std (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  sync_fifo_fwft #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (32),
    .FWFT       (1)
  ) u_fwft (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_std(input string tag,
                         input int lvl,
                         input logic full,
                         input logic empty,
                         input logic af,
                         input logic ae);
    chk({tag, ".level"}, 32'(bus0.level_o), 32'(lvl));
    chk({tag, ".full"}, 32'(bus0.full_o), 32'(full));
    chk({tag, ".empty"}, 32'(bus0.empty_o), 32'(empty));
    chk({tag, ".af"}, 32'(bus0.almost_full_o), 32'(af));
    chk({tag, ".ae"}, 32'(bus0.almost_empty_o), 32'(ae));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.flush_i = 0; bus0.wr_en_i = 0;
    bus0.rd_en_i = 0; bus0.wr_data_i = '0;
    bus1.flush_i = 0; bus1.wr_en_i = 0;
    bus1.rd_en_i = 0; bus1.wr_data_i = '0;

    #2;
    chk_std("rst", 0, 0, 1, 0, 1);
    chk("rst.data", bus0.rd_data_o, 32'h0);
    chk("rst.ovf", 32'(bus0.overflow_o), 0);
    chk("rst.udf", 32'(bus0.underflow_o), 0);
    chk("rst.fw_empty", 32'(bus1.empty_o), 1);
    chk("rst.fw_level", 32'(bus1.level_o), 0);
    tick();
    rst = 1'b0;

    // Fill the standard FIFO.
    for (int k = 1; k <= 8; k++) begin
      bus0.wr_en_i = 1;
      bus0.wr_data_i = 32'h10 + 32'(k - 1);
      tick();
      chk_std($sformatf("fill%0d", k), k, k == 8,
              0, k >= 6, k <= 1);
    end
    bus0.wr_data_i = 32'h18;
    tick();
    bus0.wr_en_i = 0;
    chk("ovf.flag", 32'(bus0.overflow_o), 1);
    chk("ovf.level", 32'(bus0.level_o), 8);
    chk("ovf.full", 32'(bus0.full_o), 1);

    // Drain it.
    for (int k = 1; k <= 8; k++) begin
      bus0.rd_en_i = 1;
      tick();
      chk($sformatf("pop%0d.data", k),
          bus0.rd_data_o, 32'h10 + 32'(k - 1));
      chk_std($sformatf("pop%0d", k), 8 - k, 0,
              k == 8, 8 - k >= 6, 8 - k <= 1);
    end
    tick();
    bus0.rd_en_i = 0;
    chk("udf.flag", 32'(bus0.underflow_o), 1);
    chk("udf.data", bus0.rd_data_o, 32'h17);
    chk("udf.ovf_sticky", 32'(bus0.overflow_o), 1);

    bus0.flush_i = 1;
    tick();
    bus0.flush_i = 0;
    chk("flush1.ovf", 32'(bus0.overflow_o), 0);
    chk("flush1.udf", 32'(bus0.underflow_o), 0);
    chk("flush1.data", bus0.rd_data_o, 32'h17);
    chk_std("flush1", 0, 0, 1, 0, 1);

    // Level 4 then 40 cycles of push+pop.
    for (int k = 0; k < 4; k++) begin
      bus0.wr_en_i = 1;
      bus0.wr_data_i = 32'h20 + 32'(k);
      tick();
    end
    chk("pre.level", 32'(bus0.level_o), 4);
    for (int i = 0; i < 40; i++) begin
      bus0.wr_en_i = 1;
      bus0.rd_en_i = 1;
      bus0.wr_data_i = 32'h24 + 32'(i);
      tick();
      chk($sformatf("strm%0d.data", i),
          bus0.rd_data_o, 32'h20 + 32'(i));
      chk($sformatf("strm%0d.level", i),
          32'(bus0.level_o), 4);
    end
    bus0.rd_en_i = 0;
    chk("strm.ovf", 32'(bus0.overflow_o), 0);
    chk("strm.udf", 32'(bus0.underflow_o), 0);

    // Refill to full, then push+pop at full.
    for (int k = 0; k < 4; k++) begin
      bus0.wr_data_i = 32'h4c + 32'(k);
      tick();
    end
    chk_std("full2", 8, 1, 0, 1, 0);
    bus0.rd_en_i = 1;
    bus0.wr_data_i = 32'h99;
    tick();
    bus0.rd_en_i = 0;
    chk("both.level", 32'(bus0.level_o), 7);
    chk("both.ovf", 32'(bus0.overflow_o), 1);
    chk("both.full", 32'(bus0.full_o), 0);
    chk("both.data", bus0.rd_data_o, 32'h48);
    bus0.flush_i = 1;
    tick();
    bus0.flush_i = 0;
    bus0.wr_en_i = 0;
    chk_std("flush2", 0, 0, 1, 0, 1);
    chk("flush2.ovf", 32'(bus0.overflow_o), 0);
    chk("flush2.data", bus0.rd_data_o, 32'h48);

    // Async reset mid-cycle at level 5.
    for (int k = 0; k < 5; k++) begin
      bus0.wr_en_i = 1;
      bus0.wr_data_i = 32'h60 + 32'(k);
      tick();
    end
    bus0.wr_en_i = 0;
    chk("arst.pre", 32'(bus0.level_o), 5);
    #3;
    rst = 1'b1;
    #1;
    chk_std("arst", 0, 0, 1, 0, 1);
    chk("arst.data", bus0.rd_data_o, 32'h0);
    #2;
    rst = 1'b0;
    bus0.wr_en_i = 1;
    bus0.wr_data_i = 32'h77;
    tick();
    bus0.wr_en_i = 0;
    chk_std("post", 1, 0, 0, 0, 1);
    bus0.rd_en_i = 1;
    tick();
    bus0.rd_en_i = 0;
    chk("post.data", bus0.rd_data_o, 32'h77);
    chk("post.empty", 32'(bus0.empty_o), 1);

    // FWFT: single word latency.
    bus1.wr_en_i = 1;
    bus1.wr_data_i = 32'hab;
    tick();
    bus1.wr_en_i = 0;
    chk("fw1.empty", 32'(bus1.empty_o), 1);
    chk("fw1.level", 32'(bus1.level_o), 1);
    tick();
    chk("fw2.empty", 32'(bus1.empty_o), 0);
    chk("fw2.data", bus1.rd_data_o, 32'hab);
    bus1.rd_en_i = 1;
    tick();
    bus1.rd_en_i = 0;
    chk("fw3.empty", 32'(bus1.empty_o), 1);
    chk("fw3.level", 32'(bus1.level_o), 0);
    chk("fw3.udf", 32'(bus1.underflow_o), 0);

    // FWFT: fill, overflow, drain.
    for (int k = 1; k <= 8; k++) begin
      bus1.wr_en_i = 1;
      bus1.wr_data_i = 32'hd0 + 32'(k - 1);
      tick();
      chk($sformatf("fwfill%0d.level", k),
          32'(bus1.level_o), 32'(k));
      chk($sformatf("fwfill%0d.full", k),
          32'(bus1.full_o), 32'(k == 8));
    end
    bus1.wr_data_i = 32'hd8;
    tick();
    bus1.wr_en_i = 0;
    chk("fwovf.flag", 32'(bus1.overflow_o), 1);
    chk("fwovf.level", 32'(bus1.level_o), 8);
    chk("fwovf.head", bus1.rd_data_o, 32'hd0);
    for (int k = 1; k <= 8; k++) begin
      bus1.rd_en_i = 1;
      tick();
      chk($sformatf("fwpop%0d.level", k),
          32'(bus1.level_o), 32'(8 - k));
      chk($sformatf("fwpop%0d.empty", k),
          32'(bus1.empty_o), 32'(k == 8));
      if (k < 8) begin
        chk($sformatf("fwpop%0d.data", k),
            bus1.rd_data_o, 32'hd0 + 32'(k));
      end
    end
    tick();
    bus1.rd_en_i = 0;
    chk("fwudf.flag", 32'(bus1.underflow_o), 1);
    bus1.flush_i = 1;
    tick();
    bus1.flush_i = 0;
    chk("fwflush.ovf", 32'(bus1.overflow_o), 0);
    chk("fwflush.udf", 32'(bus1.underflow_o), 0);
    chk("fwflush.empty", 32'(bus1.empty_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
